// File: rtl/xbar_slot_arbiter.sv
// Per-slot crossbar scheduler: samples requests at slot_start, round-robin per output, one output per cycle.
// Latency: slot_start sampled at edge T, configuration and cfg_valid visible after edge T+N_PORTS+1.
// No backpressure; a slot_start while busy is dropped and flagged in the sticky overrun bit.
module xbar_slot_arbiter #(
  parameter int N_PORTS = 8,
  parameter int SEL_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       slot_start,
  input  logic [N_PORTS-1:0]         req_valid,
  input  logic [N_PORTS*SEL_W-1:0]   req_dest,
  input  logic                       clr_overrun,
  output logic [N_PORTS*SEL_W-1:0]   out_sel,
  output logic [N_PORTS-1:0]         out_en,
  output logic [N_PORTS-1:0]         in_grant,
  output logic                       cfg_valid,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [1:0] {IDLE, ARB, COMMIT} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_PORTS - 1);

  state_t                    state_q;
  logic [SEL_W-1:0]          idx_q;
  logic [N_PORTS-1:0]        lat_vld_q;
  logic [SEL_W-1:0]          lat_dest_q [N_PORTS];
  logic [SEL_W-1:0]          ptr_q      [N_PORTS];
  logic [SEL_W-1:0]          sh_sel_q   [N_PORTS];
  logic [N_PORTS-1:0]        sh_en_q;
  logic [N_PORTS*SEL_W-1:0]  out_sel_q;
  logic [N_PORTS-1:0]        out_en_q;
  logic [N_PORTS-1:0]        in_grant_q;
  logic                      cfg_valid_q;
  logic                      overrun_q;

  logic                      win_found_d;
  logic [SEL_W-1:0]          win_sel_d;
  logic [N_PORTS-1:0]        grant_d;
  logic [N_PORTS*SEL_W-1:0]  sel_pack_d;

  // Round-robin scan for output idx_q: first latched requester for it at or after ptr, wrapping modulo N_PORTS.
  always_comb begin
    logic [SEL_W-1:0] cand;
    cand        = '0;
    win_found_d = 1'b0;
    win_sel_d   = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      cand = ptr_q[idx_q] + SEL_W'(j);
      if (!win_found_d && lat_vld_q[cand] && (lat_dest_q[cand] == idx_q)) begin
        win_found_d = 1'b1;
        win_sel_d   = cand;
      end
    end
  end

  // Pack the shadow selects and derive per-input grants for the commit cycle.
  always_comb begin
    grant_d    = '0;
    sel_pack_d = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      sel_pack_d[k*SEL_W +: SEL_W] = sh_sel_q[k];
      if (sh_en_q[k]) grant_d[sh_sel_q[k]] = 1'b1;
    end
  end

  // Slot FSM: latch requests, arbitrate one output per cycle, then commit the whole configuration at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      lat_vld_q   <= '0;
      sh_en_q     <= '0;
      out_sel_q   <= '0;
      out_en_q    <= '0;
      in_grant_q  <= '0;
      cfg_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) begin
        lat_dest_q[i] <= '0;
        ptr_q[i]      <= '0;
        sh_sel_q[i]   <= '0;
      end
    end else begin
      cfg_valid_q <= 1'b0;
      // A dropped slot_start outranks a clear in the same cycle so the event is never lost.
      if (slot_start && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (slot_start) begin
            lat_vld_q <= req_valid;
            for (int i = 0; i < N_PORTS; i++) begin
              lat_dest_q[i] <= req_dest[i*SEL_W +: SEL_W];
            end
            idx_q   <= '0;
            state_q <= ARB;
          end
        end
        ARB: begin
          sh_sel_q[idx_q] <= win_sel_d;
          sh_en_q[idx_q]  <= win_found_d;
          if (idx_q == LAST_IDX) begin
            state_q <= COMMIT;
          end else begin
            idx_q <= idx_q + SEL_W'(1);
          end
        end
        COMMIT: begin
          out_sel_q   <= sel_pack_d;
          out_en_q    <= sh_en_q;
          in_grant_q  <= grant_d;
          cfg_valid_q <= 1'b1;
          // Winners move to the back of the line; idle outputs keep their position.
          for (int k = 0; k < N_PORTS; k++) begin
            if (sh_en_q[k]) ptr_q[k] <= sh_sel_q[k] + SEL_W'(1);
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_sel   = out_sel_q;
  assign out_en    = out_en_q;
  assign in_grant  = in_grant_q;
  assign cfg_valid = cfg_valid_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
